// File: rtl/sumador_nbits_display.sv
// Registered add/subtract unit with two-deep result history and a multiplexed hex display.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zero digits above digit 0.
module sumador_nbits_display #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned DIGITS      = 3,
  parameter int unsigned REFRESH_DIV = 50000
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic [WIDTH-1:0]  A,
  input  logic [WIDTH-1:0]  B,
  input  logic              Load,
  input  logic              Mode,
  input  logic              Sel,
  output logic [WIDTH:0]    Q0,
  output logic [WIDTH:0]    Q1,
  output logic              Ovf,
  output logic              Res_Valid,
  output logic [6:0]        Seg,
  output logic [DIGITS-1:0] Dig_En
);

  localparam int unsigned ScanW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned DigW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned PadW  = 4 * DIGITS;

  function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
    logic [6:0] g;
    unique case (nib)
      4'h0: g = 7'b0111111;
      4'h1: g = 7'b0000110;
      4'h2: g = 7'b1011011;
      4'h3: g = 7'b1001111;
      4'h4: g = 7'b1100110;
      4'h5: g = 7'b1101101;
      4'h6: g = 7'b1111101;
      4'h7: g = 7'b0000111;
      4'h8: g = 7'b1111111;
      4'h9: g = 7'b1101111;
      4'hA: g = 7'b1110111;
      4'hB: g = 7'b1111100;
      4'hC: g = 7'b0111001;
      4'hD: g = 7'b1011110;
      4'hE: g = 7'b1111001;
      4'hF: g = 7'b1110001;
    endcase
    return g;
  endfunction

  logic [WIDTH:0]    q0_q, q0_d, q1_q, q1_d;
  logic              ovf_q, ovf_d, valid_q, valid_d;
  logic [ScanW-1:0]  scan_q, scan_d;
  logic [DigW-1:0]   dig_q, dig_d;
  logic [6:0]        seg_q, seg_d;
  logic [DIGITS-1:0] dig_en_q, dig_en_d;

  logic [WIDTH:0]    res_add, res_sub;
  logic              ovf_add, ovf_sub;
  logic [PadW-1:0]   padded;
  logic [3:0]        nib;

  always_comb begin
    res_add = {1'b0, A} + {1'b0, B};
    res_sub = {1'b0, A} - {1'b0, B};
    // Signed overflow: result sign disagrees with what the operand signs imply.
    ovf_add = (A[WIDTH-1] == B[WIDTH-1]) && (res_add[WIDTH-1] != A[WIDTH-1]);
    ovf_sub = (A[WIDTH-1] != B[WIDTH-1]) && (res_sub[WIDTH-1] != A[WIDTH-1]);

    q0_d    = q0_q;
    q1_d    = q1_q;
    ovf_d   = ovf_q;
    valid_d = Load;
    if (Load) begin
      q1_d  = q0_q;
      q0_d  = Mode ? res_sub : res_add;
      ovf_d = Mode ? ovf_sub : ovf_add;
    end

    scan_d = scan_q + ScanW'(1);
    dig_d  = dig_q;
    if (scan_q == ScanW'(REFRESH_DIV - 1)) begin
      scan_d = '0;
      dig_d  = (dig_q == DigW'(DIGITS - 1)) ? '0 : dig_q + DigW'(1);
    end

    padded          = '0;
    padded[WIDTH:0] = Sel ? q1_q : q0_q;
    nib             = 4'(padded >> {dig_q, 2'b00});
    seg_d           = hex_glyph(nib);
`ifdef LEADING_ZERO_BLANK_EN
    if ((dig_q != '0) && ((padded >> {dig_q, 2'b00}) == '0)) seg_d = 7'b0000000;
`endif
    dig_en_d = DIGITS'(1) << dig_q;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      q0_q     <= '0;
      q1_q     <= '0;
      ovf_q    <= 1'b0;
      valid_q  <= 1'b0;
      scan_q   <= '0;
      dig_q    <= '0;
      seg_q    <= 7'b0111111;
      dig_en_q <= DIGITS'(1);
    end else begin
      q0_q     <= q0_d;
      q1_q     <= q1_d;
      ovf_q    <= ovf_d;
      valid_q  <= valid_d;
      scan_q   <= scan_d;
      dig_q    <= dig_d;
      seg_q    <= seg_d;
      dig_en_q <= dig_en_d;
    end
  end

  assign Q0        = q0_q;
  assign Q1        = q1_q;
  assign Ovf       = ovf_q;
  assign Res_Valid = valid_q;
  assign Seg       = seg_q;
  assign Dig_En    = dig_en_q;

endmodule

// File: tb/tb_sumador_nbits_display.sv
// Directed bench for sumador_nbits_display: arithmetic, history, scan, glyphs, Sel and reset.
module tb_sumador_nbits_display;

  localparam int unsigned W = 8;
  localparam int unsigned D = 3;
  localparam int unsigned R = 4;

  logic         Clk = 1'b0;
  logic         Rst_n = 1'b0;
  logic [W-1:0] A = '0, B = '0;
  logic         Load = 1'b0, Mode = 1'b0, Sel = 1'b0;
  logic [W:0]   Q0, Q1;
  logic         Ovf, Res_Valid;
  logic [6:0]   Seg;
  logic [D-1:0] Dig_En;

  int checks = 0;
  int errors = 0;

  sumador_nbits_display #(.WIDTH(W), .DIGITS(D), .REFRESH_DIV(R)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .A(A), .B(B), .Load(Load), .Mode(Mode), .Sel(Sel),
    .Q0(Q0), .Q1(Q1), .Ovf(Ovf), .Res_Valid(Res_Valid), .Seg(Seg), .Dig_En(Dig_En)
  );

  always #5 Clk = ~Clk;

  localparam logic [6:0] G0 = 7'b0111111, G1 = 7'b0000110, G3 = 7'b1001111;
  localparam logic [6:0] G5 = 7'b1101101, G8 = 7'b1111111, GA = 7'b1110111;
`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] GLZ = 7'b0000000;
`else
  localparam logic [6:0] GLZ = 7'b0111111;
`endif

  task automatic test_reset();
    Rst_n = 1'b0;
    repeat (3) @(negedge Clk);
    Rst_n = 1'b1;
    #1;
    checks++; if (Q0 !== 9'h000) begin errors++; $display("FAIL reset_q0 got %h exp 000", Q0); end
    checks++; if (Q1 !== 9'h000) begin errors++; $display("FAIL reset_q1 got %h exp 000", Q1); end
    checks++; if (Ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", Ovf); end
    checks++;
    if (Res_Valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", Res_Valid); end
    checks++;
    if (Dig_En !== 3'b001) begin errors++; $display("FAIL reset_dig_en got %b exp 001", Dig_En); end
    checks++; if (Seg !== G0) begin errors++; $display("FAIL reset_seg got %b exp %b", Seg, G0); end
  endtask

  task automatic test_add_carry();
    @(negedge Clk);
    A = 8'hFF; B = 8'h01; Mode = 1'b0; Load = 1'b1;
    @(negedge Clk);
    Load = 1'b0;
    checks++; if (Q0 !== 9'h100) begin errors++; $display("FAIL add_carry_q0 got %h exp 100", Q0); end
    checks++; if (Ovf !== 1'b0) begin errors++; $display("FAIL add_carry_ovf got %b exp 0", Ovf); end
    checks++;
    if (Res_Valid !== 1'b1) begin errors++; $display("FAIL add_valid_hi got %b exp 1", Res_Valid); end
    @(negedge Clk);
    checks++;
    if (Res_Valid !== 1'b0) begin errors++; $display("FAIL add_valid_lo got %b exp 0", Res_Valid); end
    checks++; if (Q0 !== 9'h100) begin errors++; $display("FAIL add_hold_q0 got %h exp 100", Q0); end
  endtask

  task automatic test_overflow_sub();
    A = 8'h7F; B = 8'h01; Mode = 1'b0; Load = 1'b1;
    @(negedge Clk);
    checks++; if (Q0 !== 9'h080) begin errors++; $display("FAIL ovf_add_q0 got %h exp 080", Q0); end
    checks++; if (Ovf !== 1'b1) begin errors++; $display("FAIL ovf_add_ovf got %b exp 1", Ovf); end
    A = 8'h05; B = 8'h07; Mode = 1'b1;
    @(negedge Clk);
    Load = 1'b0;
    checks++; if (Q0 !== 9'h1FE) begin errors++; $display("FAIL sub_q0 got %h exp 1fe", Q0); end
    checks++; if (Ovf !== 1'b0) begin errors++; $display("FAIL sub_ovf got %b exp 0", Ovf); end
    checks++; if (Q1 !== 9'h080) begin errors++; $display("FAIL sub_q1 got %h exp 080", Q1); end
    @(negedge Clk);
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] va [3] = '{8'h80, 8'h10, 8'h80};
    logic [W-1:0] vb [3] = '{8'h01, 8'h20, 8'h80};
    logic         vm [3] = '{1'b1, 1'b1, 1'b0};
    logic [W:0]   eq [3] = '{9'h07F, 9'h1F0, 9'h100};
    logic         eo [3] = '{1'b1, 1'b0, 1'b1};
    logic [W:0]   prev;
    prev = 9'h1FE;
    for (int i = 0; i < 3; i++) begin
      A = va[i]; B = vb[i]; Mode = vm[i]; Load = 1'b1;
      @(negedge Clk);
      checks++;
      if (Q0 !== eq[i]) begin errors++; $display("FAIL b2b_q0[%0d] got %h exp %h", i, Q0, eq[i]); end
      checks++;
      if (Q1 !== prev) begin errors++; $display("FAIL b2b_q1[%0d] got %h exp %h", i, Q1, prev); end
      checks++;
      if (Ovf !== eo[i]) begin errors++; $display("FAIL b2b_ovf[%0d] got %b exp %b", i, Ovf, eo[i]); end
      checks++;
      if (Res_Valid !== 1'b1) begin
        errors++; $display("FAIL b2b_valid[%0d] got %b exp 1", i, Res_Valid);
      end
      prev = eq[i];
    end
    Load = 1'b0;
    @(negedge Clk);
    checks++;
    if (Res_Valid !== 1'b0) begin errors++; $display("FAIL b2b_valid_end got %b exp 0", Res_Valid); end
  endtask

  task automatic test_scan_glyphs();
    logic [6:0] exp_seg [3] = '{G3, GA, G1};
    int d;
    Rst_n = 1'b0;
    @(negedge Clk);
    Rst_n = 1'b1;
    A = 8'hFF; B = 8'hA4; Mode = 1'b0; Sel = 1'b0; Load = 1'b1;
    @(negedge Clk);
    Load = 1'b0;
    checks++; if (Q0 !== 9'h1A3) begin errors++; $display("FAIL scan_q0 got %h exp 1a3", Q0); end
    repeat (3) @(negedge Clk);
    checks++;
    if (Dig_En !== 3'b001 || Seg !== G3) begin
      errors++; $display("FAIL scan_first_dwell got %b/%b exp 001/%b", Dig_En, Seg, G3);
    end
    for (int i = 0; i < 12; i++) begin
      @(negedge Clk);
      d = (i / 4 + 1) % 3;
      checks++;
      if (Dig_En !== 3'(1 << d) || Seg !== exp_seg[d]) begin
        errors++;
        $display("FAIL scan[%0d] got %b/%b exp %b/%b", i, Dig_En, Seg, 3'(1 << d), exp_seg[d]);
      end
    end
  endtask

  task automatic test_sel_switch();
    logic [6:0] exp_seg [3] = '{G0, G8, GLZ};
    int d;
    A = 8'h7F; B = 8'h01; Mode = 1'b0; Load = 1'b1;
    @(negedge Clk);
    A = 8'h05; B = 8'h07; Mode = 1'b1;
    @(negedge Clk);
    Load = 1'b0;
    checks++; if (Q1 !== 9'h080) begin errors++; $display("FAIL sel_q1 got %h exp 080", Q1); end
    Sel = 1'b1;
    @(negedge Clk);
    for (int i = 0; i < 12; i++) begin
      @(negedge Clk);
      unique case (Dig_En)
        3'b001: d = 0;
        3'b010: d = 1;
        3'b100: d = 2;
        default: d = -1;
      endcase
      checks++;
      if (d < 0) begin
        errors++; $display("FAIL sel_onehot[%0d] got %b exp one-hot", i, Dig_En);
      end else if (Seg !== exp_seg[d]) begin
        errors++; $display("FAIL sel_seg[%0d] got %b exp %b (digit %0d)", i, Seg, exp_seg[d], d);
      end
    end
    Sel = 1'b0;
  endtask

  task automatic test_blank();
    logic [6:0] exp_seg [3] = '{G5, GLZ, GLZ};
    int d;
    A = 8'h05; B = 8'h00; Mode = 1'b0; Load = 1'b1;
    @(negedge Clk);
    Load = 1'b0;
    @(negedge Clk);
    for (int i = 0; i < 12; i++) begin
      @(negedge Clk);
      unique case (Dig_En)
        3'b001: d = 0;
        3'b010: d = 1;
        3'b100: d = 2;
        default: d = -1;
      endcase
      checks++;
      if (d < 0) begin
        errors++; $display("FAIL blank_onehot[%0d] got %b exp one-hot", i, Dig_En);
      end else if (Seg !== exp_seg[d]) begin
        errors++; $display("FAIL blank_seg[%0d] got %b exp %b (digit %0d)", i, Seg, exp_seg[d], d);
      end
    end
  endtask

  task automatic test_async_reset();
    A = 8'h12; B = 8'h34; Mode = 1'b0; Load = 1'b1;
    @(negedge Clk);
    checks++; if (Q0 !== 9'h046) begin errors++; $display("FAIL pre_arst_q0 got %h exp 046", Q0); end
    #2 Rst_n = 1'b0;
    #1;
    checks++;
    if (Q0 !== 9'h000 || Q1 !== 9'h000 || Ovf !== 1'b0 || Res_Valid !== 1'b0) begin
      errors++;
      $display("FAIL arst_regs got %h/%h/%b/%b exp 000/000/0/0", Q0, Q1, Ovf, Res_Valid);
    end
    checks++;
    if (Dig_En !== 3'b001 || Seg !== G0) begin
      errors++; $display("FAIL arst_display got %b/%b exp 001/%b", Dig_En, Seg, G0);
    end
    Load = 1'b0;
    @(negedge Clk);
    Rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_add_carry();
    test_overflow_sub();
    test_back_to_back();
    test_scan_glyphs();
    test_sel_switch();
    test_blank();
    test_async_reset();
    repeat (2) @(negedge Clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
